// File: rtl/fsm_sequencer.sv
// fsm_sequencer: instruction sequencer running NOP/LOOP/BRANCH/HALT with a step counter and retire pulses
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_valid/ready   instruction handshake (ready only in IDLE)
//   opcode, operand     00 NOP, 01 LOOP, 10 BRANCH, 11 HALT; loop limit or branch tag
//   cmp_valid, cmp      branch compare result
//   state, count        current state code, step counter
//   cnt_rst             counter clears at the next edge
//   done, branch_take, err  one-cycle retire pulses
//   SEQ_BRANCH_TIMEOUT_EN   when defined, an unresolved BRANCH times out after 16 cycles with err
module fsm_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [1:0] opcode,
  input  logic [3:0] operand,
  input  logic       cmp_valid,
  input  logic       cmp,
  output logic [2:0] state,
  output logic [3:0] count,
  output logic       cnt_rst,
  output logic       done,
  output logic       branch_take,
  output logic       err
);
`ifdef SEQ_BRANCH_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd7
  } state_e;
  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [1:0] op_q, op_d;
  logic [3:0] opd_q, opd_d;
  logic       done_q, done_d;
  logic       take_q, take_d;
  logic       err_q, err_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= '0;
      opd_q   <= '0;
      done_q  <= 1'b0;
      take_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      opd_q   <= opd_d;
      done_q  <= done_d;
      take_q  <= take_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    opd_d   = opd_q;
    done_d  = 1'b0;
    take_d  = 1'b0;
    err_d   = 1'b0;
    cnt_rst = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = opcode;
          opd_d   = operand;
          state_d = DECODE;
        end
      end
      DECODE: begin
        cnt_rst = 1'b1;
        done_d  = op_q == 2'd0;
        state_d = op_q == 2'd0 ? IDLE : op_q == 2'd1 ? EXEC : op_q == 2'd2 ? BRANCH : HALT;
      end
      EXEC: begin
        // exit when count reaches the limit, so the counter never wraps
        if (count_q == opd_q) begin
          state_d = IDLE;
          cnt_rst = 1'b1;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      BRANCH: begin
        // a compare result on the final timeout cycle still wins over err
        if (cmp_valid) begin
          state_d = IDLE;
          cnt_rst = 1'b1;
          take_d  = cmp;
        end else if (TIMEOUT_EN && count_q == 4'd15) begin
          state_d = IDLE;
          cnt_rst = 1'b1;
          err_d   = 1'b1;
        end else if (TIMEOUT_EN) begin
          count_d = count_q + 4'd1;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (cnt_rst) count_d = '0;
  end
  assign instr_ready = state_q == IDLE;
  assign state       = state_q;
  assign count       = count_q;
  assign done        = done_q;
  assign branch_take = take_q;
  assign err         = err_q;
endmodule

// File: tb/tb_fsm_sequencer.sv
// tb_fsm_sequencer: randomized and directed checks of fsm_sequencer against a timeline model
module tb_fsm_sequencer;
`ifdef SEQ_BRANCH_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [1:0] opcode = '0;
  logic [3:0] operand = '0;
  logic       cmp_valid = 1'b0;
  logic       cmp = 1'b0;
  logic [2:0] state;
  logic [3:0] count;
  logic       cnt_rst, done, branch_take, err;
  int n_chk = 0;
  int n_fail = 0;
  bit       mbusy = 1'b0;
  bit [1:0] mop;
  int       mn, mage;
  bit       mdone = 1'b0, mtake = 1'b0, merr = 1'b0;
  fsm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .operand(operand), .cmp_valid(cmp_valid), .cmp(cmp),
    .state(state), .count(count), .cnt_rst(cnt_rst), .done(done),
    .branch_take(branch_take), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic void model_reset();
    mbusy = 1'b0;
    mdone = 1'b0;
    mtake = 1'b0;
    merr  = 1'b0;
  endfunction
  // age counts cycles since acceptance: age 1 is DECODE, age 2.. is the working phase
  function automatic void model_update();
    bit d = 1'b0, t = 1'b0, e = 1'b0;
    if (!mbusy) begin
      if (instr_valid) begin
        mbusy = 1'b1;
        mop   = opcode;
        mn    = int'(operand);
        mage  = 1;
      end
    end else if (mage == 1 && mop == 2'd0) begin
      mbusy = 1'b0;
      d = 1'b1;
    end else if (mage >= 2 && mop == 2'd1 && mage - 2 == mn) begin
      mbusy = 1'b0;
      d = 1'b1;
    end else if (mage >= 2 && mop == 2'd2 && cmp_valid) begin
      mbusy = 1'b0;
      t = cmp;
    end else if (mage >= 2 && mop == 2'd2 && TO && mage - 2 == 15) begin
      mbusy = 1'b0;
      e = 1'b1;
    end else begin
      mage++;
    end
    mdone = d;
    mtake = t;
    merr  = e;
  endfunction
  task automatic compare();
    int es = 0, ec = 0, ecr = 0;
    if (mbusy && mage == 1) begin
      es = 2;
      ecr = 1;
    end else if (mbusy && mop == 2'd1) begin
      es = 3;
      ec = mage - 2;
      ecr = int'(mage - 2 == mn);
    end else if (mbusy && mop == 2'd2) begin
      es = 4;
      ec = TO ? mage - 2 : 0;
      ecr = int'(cmp_valid || (TO && mage - 2 == 15));
    end else if (mbusy) begin
      es = 7;
    end
    chk("state", int'(state), es);
    chk("count", int'(count), ec);
    chk("cnt_rst", int'(cnt_rst), ecr);
    chk("instr_ready", int'(instr_ready), int'(!mbusy));
    chk("done", int'(done), int'(mdone));
    chk("branch_take", int'(branch_take), int'(mtake));
    chk("err", int'(err), int'(merr));
  endtask
  task automatic step(input bit v, input bit [1:0] op, input bit [3:0] opd, input bit cv, input bit c);
    @(posedge clk);
    model_update();
    @(negedge clk);
    instr_valid = v;
    opcode      = op;
    operand     = opd;
    cmp_valid   = cv;
    cmp         = c;
    #1;
    compare();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    cmp_valid = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_pulses", int'({done, branch_take, err}), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic idle();
    step(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
  endtask
  task automatic run_loop(input bit [3:0] n, output int cycles, output int mx);
    cycles = 0;
    mx = 0;
    step(1'b1, 2'd1, n, 1'b0, 1'b0);
    repeat (int'(n) + 3) begin
      idle();
      if (state == 3'd3) begin
        cycles++;
        if (int'(count) > mx) mx = int'(count);
      end
    end
  endtask
  initial begin
    int cyc, mx, hc;
    #2;
    do_reset();
    idle();
    chk("ready_after_rst", int'(instr_ready), 1);
    // LOOP 3 timeline
    step(1'b1, 2'd1, 4'd3, 1'b0, 1'b0);
    idle();
    chk("loop3_decode", int'(state), 2);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("loop3_exec", int'(state), 3);
      chk("loop3_count", int'(count), k);
    end
    idle();
    chk("loop3_done", int'(done), 1);
    chk("loop3_idle", int'(state), 0);
    // NOP retires in two cycles
    step(1'b1, 2'd0, 4'd9, 1'b0, 1'b0);
    idle();
    idle();
    chk("nop_done", int'(done), 1);
    // LOOP extremes
    run_loop(4'd0, cyc, mx);
    chk("loop0_len", cyc, 1);
    chk("loop0_max", mx, 0);
    run_loop(4'd15, cyc, mx);
    chk("loop15_len", cyc, 16);
    chk("loop15_max", mx, 15);
    // BRANCH resolved on its third cycle, taken then not taken
    for (int t = 1; t >= 0; t--) begin
      step(1'b1, 2'd2, 4'd5, 1'b0, 1'b0);
      idle();
      idle();
      idle();
      step(1'b0, 2'd0, 4'd0, 1'b1, t[0]);
      chk("br_cnt_rst", int'(cnt_rst), 1);
      idle();
      chk("br_take", int'(branch_take), t);
      chk("br_state", int'(state), 0);
      chk("br_count", int'(count), 0);
      idle();
      chk("br_take_pulse", int'(branch_take), 0);
    end
    // BRANCH with no compare result
    step(1'b1, 2'd2, 4'd1, 1'b0, 1'b0);
    idle();
    if (TO) begin
      repeat (17) idle();
      chk("br_timeout_err", int'(err), 1);
      chk("br_timeout_state", int'(state), 0);
      idle();
      chk("br_err_pulse", int'(err), 0);
    end else begin
      repeat (100) idle();
      chk("br_wait_state", int'(state), 4);
      chk("br_wait_err", int'(err), 0);
      step(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
      idle();
    end
    // HALT ignores further instructions until reset
    step(1'b1, 2'd3, 4'd0, 1'b0, 1'b0);
    idle();
    hc = 0;
    repeat (20) begin
      step(1'b1, 2'($urandom), 4'($urandom), 1'b0, 1'b0);
      if (state == 3'd7 && !instr_ready) hc++;
    end
    chk("halt_hold", hc, 20);
    do_reset();
    idle();
    chk("halt_rst_state", int'(state), 0);
    chk("halt_rst_ready", int'(instr_ready), 1);
    // reset mid-EXEC at count 2
    step(1'b1, 2'd1, 4'd6, 1'b0, 1'b0);
    idle();
    idle();
    idle();
    idle();
    chk("mid_exec_count", int'(count), 2);
    do_reset();
    hc = 0;
    repeat (10) begin
      idle();
      hc += int'(done);
    end
    chk("abort_no_done", hc, 0);
    // randomized traffic
    repeat (3000) begin
      if ((mbusy && mop == 2'd3 && mage > 6) || $urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom), 2'($urandom), 4'($urandom), $urandom_range(0, 3) == 0, 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fsm_sequencer.md
FSM_SEQUENCER -- requirements
Module: fsm_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have the following ports: instr_valid  in  1  instruction offered.
REQ-003 The block SHALL have: instr_ready  out  1  instruction accepted when high with instr_valid.
REQ-004 The block SHALL have: opcode  in  2  00 NOP, 01 LOOP, 10 BRANCH, 11 HALT.
REQ-005 The block SHALL have: operand  in  4  loop limit or branch tag.
REQ-006 The block SHALL have: cmp_valid  in  1  compare result available; cmp  in  1  compare result.
REQ-007 The block SHALL have: state  out  3  current state encoding; count  out  4  step counter.
REQ-008 The block SHALL have: cnt_rst  out  1  counter clears at next edge (combinational).
REQ-009 The block SHALL have: done  out  1  one-cycle pulse, LOOP/NOP retired.
REQ-010 The block SHALL have: branch_take  out  1  one-cycle pulse, branch resolved taken.
REQ-011 The block SHALL have: err  out  1  one-cycle pulse, branch timeout.

Function
REQ-012 The state encodings SHALL be IDLE=0, DECODE=2, EXEC=3, BRANCH=4 and HALT=7; all other codes SHALL go to IDLE on the next edge.
REQ-013 instr_ready SHALL be 1 only in IDLE.
REQ-014 On instr_valid&instr_ready, the block SHALL latch opcode and operand and enter DECODE on the next edge.
REQ-015 In DECODE:
- NOP SHALL go to IDLE with done=1 for one cycle.
- LOOP SHALL go to EXEC.
- BRANCH SHALL go to BRANCH.
- HALT SHALL go to HALT.
REQ-016 cnt_rst SHALL be 1 in DECODE and on every transition out of EXEC or BRANCH; count SHALL be 0 on entry to EXEC and BRANCH.
REQ-017 In EXEC, count SHALL increment by 1 per cycle.
REQ-018 When count equals the latched operand in EXEC, the block SHALL return to IDLE with done=1 and count=0 on the next edge.
REQ-019 EXEC SHALL last exactly operand+1 cycles (operand 0 gives 1 cycle; operand 15 gives 16 cycles, and count never wraps).
REQ-020 In BRANCH, when cmp_valid=1 the block SHALL return to IDLE, and branch_take SHALL equal cmp for one cycle.
REQ-021 HALT SHALL be held until rst_n is asserted; instr_valid SHALL be ignored in HALT.
REQ-022 done, branch_take and err SHALL never be high in the same cycle.
REQ-023 Instruction-to-instruction throughput SHALL be at minimum: NOP 2 cycles, LOOP operand+3 cycles.
REQ-024 Inputs opcode and operand SHALL be sampled only at acceptance; later changes SHALL have no effect.

Reset
REQ-025 While rst_n=0, outputs SHALL be: state=0 (IDLE), count=0, done=0, branch_take=0, err=0, latched opcode/operand=0; instr_ready SHALL be 1 after rst_n deasserts.
REQ-026 Reset asserted mid-EXEC or mid-BRANCH SHALL abort the operation immediately, with no done, branch_take or err pulse.
REQ-027 Reset deassertion SHALL be synchronised externally; the block SHALL leave IDLE no earlier than the first edge after rst_n=1.

Configuration
REQ-028 With SEQ_BRANCH_TIMEOUT_EN defined:
- in BRANCH, count SHALL increment each cycle while cmp_valid=0;
- when count reaches 15 with cmp_valid=0, the block SHALL return to IDLE with err=1 for one cycle;
- cmp_valid=1 on that same cycle SHALL take priority (normal resolution, no err).
REQ-029 With SEQ_BRANCH_TIMEOUT_EN undefined:
- BRANCH SHALL wait indefinitely;
- count SHALL hold 0 in BRANCH;
- err SHALL be tied 0.

Verification
REQ-030 LOOP with operand=3 accepted at cycle 0 -> DECODE at cycle 1, EXEC cycles 2-5 with count 0,1,2,3, done=1 at cycle 6 with state=0.
REQ-031 LOOP with operand=0 and operand=15 -> EXEC lasts 1 and 16 cycles respectively, with count max 0 and 15 and no wrap.
REQ-032 BRANCH with cmp_valid=1, cmp=1 at the third BRANCH cycle -> branch_take=1 for one cycle, state=0, count=0; repeating with cmp=0 -> no pulse.
REQ-033 BRANCH with cmp_valid held 0 -> with SEQ_BRANCH_TIMEOUT_EN, err=1 after count=15 (16 cycles); without the macro, the block remains in state=4 for 100 cycles with err=0.
REQ-034 HALT accepted, then instr_valid=1 for 20 cycles -> state=7 and instr_ready=0 throughout; rst_n pulse -> state=0 and instr_ready=1.
REQ-035 rst_n asserted during EXEC at count=2 -> state=0 and count=0 immediately, with no done pulse observed.
